// File: rtl/led_stream_pkg.sv
// Shared types and default timing for the one-wire LED stream decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_stream_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } dec_state_t;

    typedef logic [23:0] pixel_t;

    localparam int PIXEL_BITS          = 24;
    localparam int DEF_THRESH_CYCLES   = 60;
    localparam int DEF_MAX_HIGH_CYCLES = 200;
    localparam int DEF_LATCH_CYCLES    = 5000;
    localparam int DEF_NUM_PIXELS      = 32;

endpackage

// File: rtl/led_din_sync.sv
// Two-flop synchronizer bringing the asynchronous LED data line into clk.
// Latency: 2 clk cycles from din to din_s.
// Backpressure: none; free-running sampler.
module led_din_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic din_s
);

    logic din_meta;

    // Two back-to-back flops; din_meta may go metastable, din_s is the clean copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
        end
    end

endmodule

// File: rtl/led_stream_decoder.sv
// Decodes a one-wire NRZ GRB LED stream into 24-bit pixels with frame/latch detection.
// Latency: pixel_valid one cycle after the falling edge of bit 24 (3 cycles after din due to sync).
// Backpressure: none; the stream cannot be stalled. Optional frame buffer: LED_DEC_FRAMEBUF_EN.
module led_stream_decoder
    import led_stream_pkg::*;
#(
    parameter int THRESH_CYCLES   = DEF_THRESH_CYCLES,
    parameter int MAX_HIGH_CYCLES = DEF_MAX_HIGH_CYCLES,
    parameter int LATCH_CYCLES    = DEF_LATCH_CYCLES,
    parameter int NUM_PIXELS      = DEF_NUM_PIXELS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic [4:0]  pixel_index,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        err,
    input  logic [4:0]  rd_addr,
    output logic [23:0] rd_data
);

    localparam int HW = $clog2(MAX_HIGH_CYCLES + 1);
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam logic [HW-1:0] HIGH_MAX = HW'(MAX_HIGH_CYCLES);
    localparam logic [HW-1:0] HIGH_TH  = HW'(THRESH_CYCLES);
    localparam logic [LW-1:0] LOW_MAX  = LW'(LATCH_CYCLES);
    localparam logic [5:0]    IDX_FULL = 6'(NUM_PIXELS);

    logic          din_s;
    dec_state_t    state, state_d;
    logic [HW-1:0] high_cnt, high_d, high_inc;
    logic [LW-1:0] low_cnt, low_d, low_inc;
    logic [4:0]    bit_cnt, bit_d;
    logic [22:0]   shift, shift_d;
    pixel_t        word_d;
    logic          bit_val;
    logic          word_done, latch_hit, fault_hit, sync_hit, pix_accept;
    logic [5:0]    next_idx;

    led_din_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .din_s (din_s)
    );

    // Saturating increments; the counters never wrap.
    assign high_inc   = (high_cnt == HIGH_MAX) ? high_cnt : high_cnt + 1'b1;
    assign low_inc    = (low_cnt == LOW_MAX) ? low_cnt : low_cnt + 1'b1;
    assign pix_accept = word_done && (next_idx != IDX_FULL);

    // Next-state and counter logic; a latch threshold wins over a same-cycle edge.
    always_comb begin
        state_d   = state;
        high_d    = high_cnt;
        low_d     = low_cnt;
        bit_d     = bit_cnt;
        bit_val   = 1'b0;
        word_d    = {shift, 1'b0};
        shift_d   = shift;
        word_done = 1'b0;
        latch_hit = 1'b0;
        fault_hit = 1'b0;
        sync_hit  = 1'b0;
        case (state)
            SYNC: begin
                if (din_s) begin
                    low_d = '0;
                end else if (low_inc == LOW_MAX) begin
                    low_d    = '0;
                    state_d  = IDLE;
                    sync_hit = 1'b1;
                end else begin
                    low_d = low_inc;
                end
            end
            IDLE: begin
                if (din_s) begin
                    state_d = HIGH;
                    high_d  = HW'(1);
                end
            end
            HIGH: begin
                if (!din_s) begin
                    bit_val = (high_cnt >= HIGH_TH);
                    word_d  = {shift, bit_val};
                    shift_d = word_d[22:0];
                    high_d  = '0;
                    low_d   = LW'(1);
                    state_d = LOW;
                    if (bit_cnt == 5'd23) begin
                        word_done = 1'b1;
                        bit_d     = '0;
                    end else begin
                        bit_d = bit_cnt + 5'd1;
                    end
                end else if (high_inc == HIGH_MAX) begin
                    fault_hit = 1'b1;
                    state_d   = SYNC;
                    high_d    = '0;
                    low_d     = '0;
                    bit_d     = '0;
                end else begin
                    high_d = high_inc;
                end
            end
            LOW: begin
                if (low_inc == LOW_MAX) begin
                    latch_hit = 1'b1;
                    state_d   = IDLE;
                    low_d     = '0;
                    bit_d     = '0;
                end else if (din_s) begin
                    state_d = HIGH;
                    high_d  = HW'(1);
                    low_d   = '0;
                end else begin
                    low_d = low_inc;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // State, counters, pixel outputs and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SYNC;
            high_cnt    <= '0;
            low_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            next_idx    <= '0;
            pixel_data  <= '0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            high_cnt    <= high_d;
            low_cnt     <= low_d;
            bit_cnt     <= bit_d;
            shift       <= shift_d;
            pixel_valid <= pix_accept;
            frame_done  <= latch_hit;
            if (pix_accept) begin
                pixel_data  <= word_d;
                pixel_index <= next_idx[4:0];
                next_idx    <= next_idx + 6'd1;
            end
            if (word_done && !pix_accept) begin
                err <= 1'b1;
            end
            if (latch_hit) begin
                next_idx    <= '0;
                pixel_index <= '0;
                if (bit_cnt != 5'd0) begin
                    err <= 1'b1;
                end
            end
            if (fault_hit) begin
                err      <= 1'b1;
                next_idx <= '0;
            end
            if (sync_hit) begin
                next_idx <= '0;
            end
        end
    end

`ifdef LED_DEC_FRAMEBUF_EN
    pixel_t frame_mem [NUM_PIXELS];

    // Store every accepted pixel; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && pix_accept) begin
            frame_mem[next_idx[4:0]] <= word_d;
        end
    end

    // Registered read port, one cycle from rd_addr to rd_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (int'(rd_addr) < NUM_PIXELS) begin
            rd_data <= frame_mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif

endmodule

// File: doc/led_stream_decoder.md
LED_STREAM_DECODER -- requirements
Module: led_stream_decoder

Interface
REQ-001 SHALL have parameter THRESH_CYCLES, default 60, high-pulse length in clk cycles at or above which a bit decodes as 1.
REQ-002 SHALL have parameter MAX_HIGH_CYCLES, default 200, high-pulse length in cycles at which the pulse is a fault.
REQ-003 SHALL have parameter LATCH_CYCLES, default 5000, low length in cycles that ends a frame.
REQ-004 SHALL have parameter NUM_PIXELS, default 32, number of pixels accepted per frame (one per dark board square).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is synchronous to it.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port din, input, 1 bit, asynchronous one-wire NRZ LED data stream (GRB, MSB first).
REQ-008 SHALL have port pixel_data, output, 24 bits, last decoded GRB word.
REQ-009 SHALL have port pixel_index, output, 5 bits, index of pixel_data within the current frame.
REQ-010 SHALL have port pixel_valid, output, 1 bit, one-cycle strobe when pixel_data and pixel_index update.
REQ-011 SHALL have port frame_done, output, 1 bit, one-cycle strobe on latch detection.
REQ-012 SHALL have port err, output, 1 bit, sticky fault flag, cleared only by reset.
REQ-013 SHALL have port rd_addr, input, 5 bits, frame-buffer read address.
REQ-014 SHALL have port rd_data, output, 24 bits, frame-buffer read data.

Function
REQ-015 SHALL pass din through a two-flop synchronizer; din_s (second flop) is the reference for all timing below.
REQ-016 SHALL implement states SYNC, IDLE, HIGH and LOW.
REQ-017 SYNC: waits until din_s has been low for LATCH_CYCLES consecutive cycles, then -> IDLE; no pixel or frame_done output is produced.
REQ-018 IDLE: on rising din_s -> HIGH with the high counter set to 1.
REQ-019 HIGH: increments the high counter each cycle; on falling din_s it samples bit = (count >= THRESH_CYCLES), shifts the bit into the 24-bit shifter MSB first, and goes -> LOW with the low counter set to 1.
REQ-020 HIGH: when the high counter reaches MAX_HIGH_CYCLES, SHALL set err, discard the partial pixel and go -> SYNC.
REQ-021 LOW: increments the low counter; rising din_s -> HIGH; the low counter reaching LATCH_CYCLES -> IDLE.
REQ-022 On the 24th bit, SHALL pulse pixel_valid for exactly one cycle, one cycle after the falling-edge cycle, with the shifter value and the current index; the bit counter then returns to 0.
REQ-023 pixel_index SHALL increment after each valid pixel and return to 0 at every latch.
REQ-024 Pixels beyond NUM_PIXELS-1 SHALL be dropped (no pixel_valid, no buffer write) and SHALL set err; the index saturates at NUM_PIXELS-1.
REQ-025 Latch detection SHALL pulse frame_done for one cycle; if the bit counter is nonzero, SHALL set err and discard the partial bits.
REQ-026 Counters SHALL saturate and never wrap.
REQ-027 A din edge in the same cycle as a latch threshold SHALL be treated as latch first, then the edge on the next state.

Reset
REQ-028 On reset, SHALL go to SYNC with pixel_data=0, pixel_index=0, pixel_valid=0, frame_done=0, err=0, all counters 0, and rd_data=0 on the next cycle.
REQ-029 Reset mid-pixel SHALL discard all partial data; the frame buffer contents are not cleared.

Configuration
REQ-030 With LED_DEC_FRAMEBUF_EN defined, SHALL include a NUM_PIXELS x 24 buffer written on each pixel_valid, with rd_data registered one cycle after rd_addr.
REQ-031 Without LED_DEC_FRAMEBUF_EN, SHALL omit the buffer and hold rd_data at 0.

Structure
REQ-032 Package led_stream_pkg SHALL hold the state enum, the 24-bit pixel typedef and the default timing constants.
REQ-033 The synchronizer SHALL be sub-module led_din_sync; all other logic stays in one module.

Verification
REQ-034 Reset, 5000-cycle low, then 24 bits of 0x00FF00 (1 = 80 high/45 low, 0 = 35 high/90 low) -> one pixel_valid, pixel_data=0x00FF00, pixel_index=0.
REQ-035 32 pixels followed by a 5000-cycle low -> 32 strobes with indices 0..31, one frame_done, err=0; buffer readback matches with 1-cycle latency.
REQ-036 33rd pixel in a frame -> no strobe for it, err=1, pixel_index stays 31.
REQ-037 12 bits then latch -> frame_done=1, err=1, no pixel_valid; next frame starts at index 0.
REQ-038 High held for 200 cycles -> err=1, state SYNC, no output until a 5000-cycle low is seen.
REQ-039 Reset asserted at bit 10 -> all outputs 0; no output until a latch is seen; a following full pixel decodes correctly.
